// File: rtl/joystick_conditioner_if.sv
// joystick_conditioner_if: ADC sample inputs and debounced direction outputs of the joystick conditioner
interface joystick_conditioner_if #(parameter int ADC_W = 12);
  logic sample_valid;
  logic [ADC_W-1:0] adc_x;
  logic [ADC_W-1:0] adc_y;
  logic [1:0] x_axis;
  logic [1:0] y_axis;
  logic dir_changed;
  modport master(output sample_valid, adc_x, adc_y, input x_axis, y_axis, dir_changed);
  modport slave(input sample_valid, adc_x, adc_y, output x_axis, y_axis, dir_changed);
endinterface

// File: rtl/joystick_conditioner.sv
// joystick_conditioner: hysteresis classification and debounce of two ADC axes into 2-bit direction codes
module joystick_conditioner #(
  parameter int ADC_W = 12,
  parameter int LOW_TH = 1024,
  parameter int HIGH_TH = 3072,
  parameter int HYST = 128,
  parameter int DEBOUNCE = 4
) (
  input logic clk,
  input logic reset,
  joystick_conditioner_if.slave js
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [ADC_W-1:0] HI = ADC_W'(HIGH_TH);
  localparam logic [ADC_W-1:0] LO = ADC_W'(LOW_TH);
  localparam logic [ADC_W-1:0] HI_H = ADC_W'(HIGH_TH - HYST);
  localparam logic [ADC_W-1:0] LO_H = ADC_W'(LOW_TH + HYST);
  logic [1:0] com [2];
  logic [1:0] cand [2];
  logic [CW-1:0] cnt [2];
  logic [1:0] com_n [2];
  logic [1:0] cand_n [2];
  logic [CW-1:0] cnt_n [2];
  logic [1:0] cls [2];
  logic [CW-1:0] run [2];
  logic [ADC_W-1:0] smp [2];
  logic [1:0] hit;
  logic dir;
  // The committed code widens its own band by HYST so it is sticky near the threshold
  function automatic logic [1:0] classify(input logic [ADC_W-1:0] s, input logic [1:0] c);
    return (c == 2'b01) ? ((s >= HI_H) ? 2'b01 : (s <= LO) ? 2'b10 : 2'b00) :
           (c == 2'b10) ? ((s <= LO_H) ? 2'b10 : (s >= HI) ? 2'b01 : 2'b00) :
                          ((s >= HI) ? 2'b01 : (s <= LO) ? 2'b10 : 2'b00);
  endfunction
  always_comb begin
    smp[0] = js.adc_x;
    smp[1] = js.adc_y;
    for (int i = 0; i < 2; i++) begin
      cls[i] = classify(smp[i], com[i]);
      run[i] = (cls[i] == cand[i]) ? cnt[i] + 1'b1 : CW'(1);
      hit[i] = (cls[i] != com[i]) && (run[i] == CW'(DEBOUNCE));
      com_n[i] = hit[i] ? cls[i] : com[i];
      cand_n[i] = (cls[i] == com[i]) ? com[i] : cls[i];
      cnt_n[i] = ((cls[i] == com[i]) || hit[i]) ? '0 : run[i];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      com <= '{default: '0};
      cand <= '{default: '0};
      cnt <= '{default: '0};
      dir <= 1'b0;
    end else if (js.sample_valid) begin
      com <= com_n;
      cand <= cand_n;
      cnt <= cnt_n;
      dir <= |hit;
    end else begin
      dir <= 1'b0;
    end
  end
  assign js.x_axis = com[0];
  assign js.y_axis = com[1];
  assign js.dir_changed = dir;
endmodule

// File: tb/tb_joystick_conditioner.sv
// tb_joystick_conditioner: table-driven directed checks of the joystick conditioner, plus a DEBOUNCE=1 sequence
module tb_joystick_conditioner;
  localparam logic [11:0] M = 12'd2048;
  typedef struct {
    logic r;
    logic v;
    logic [11:0] x;
    logic [11:0] y;
    logic [1:0] ex;
    logic [1:0] ey;
    logic ed;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  logic rst1;
  int n = 0;
  int err = 0;
  vec_t tv[$];
  joystick_conditioner_if #(.ADC_W(12)) j();
  joystick_conditioner_if #(.ADC_W(12)) j1();
  joystick_conditioner dut (.clk(clk), .reset(reset), .js(j));
  joystick_conditioner #(.DEBOUNCE(1)) dut1 (.clk(clk), .reset(rst1), .js(j1));
  always #5 clk = ~clk;
  task automatic add(input logic r, v, input logic [11:0] x, y, input logic [1:0] ex, ey, input logic ed);
    vec_t t;
    t.r = r; t.v = v; t.x = x; t.y = y; t.ex = ex; t.ey = ey; t.ed = ed;
    tv.push_back(t);
  endtask
  task automatic rep(input int k, input logic r, v, input logic [11:0] x, y, input logic [1:0] ex, ey, input logic ed);
    for (int i = 0; i < k; i++) add(r, v, x, y, ex, ey, ed);
  endtask
  task automatic chk(input string nm, input logic [1:0] ax, ay, input logic dc, input logic [1:0] ex, ey, input logic ed);
    n++;
    if ({ax, ay, dc} !== {ex, ey, ed}) begin
      err++;
      $display("FAIL %s: got x=%b y=%b dc=%b, want x=%b y=%b dc=%b", nm, ax, ay, dc, ex, ey, ed);
    end
  endtask
  task automatic step1(input logic v, input logic [11:0] x, y, input logic [1:0] ex, ey, input logic ed, input string nm);
    j1.sample_valid = v; j1.adc_x = x; j1.adc_y = y;
    @(posedge clk); #1;
    chk(nm, j1.x_axis, j1.y_axis, j1.dir_changed, ex, ey, ed);
  endtask
  initial begin
    rst1 = 1'b1;
    j1.sample_valid = 1'b0; j1.adc_x = M; j1.adc_y = M;
    rep(3, 1, 1, 4000, M, 0, 0, 0);
    rep(3, 0, 1, 3500, M, 0, 0, 0); add(0, 1, 3500, M, 1, 0, 1); add(0, 0, M, M, 1, 0, 0);
    rep(5, 0, 1, 3000, M, 1, 0, 0);
    rep(3, 0, 1, 2900, M, 1, 0, 0); add(0, 1, 2900, M, 0, 0, 1); add(0, 0, M, M, 0, 0, 0);
    rep(3, 0, 1, 3500, M, 0, 0, 0); add(0, 1, M, M, 0, 0, 0);
    rep(3, 0, 1, 3500, M, 0, 0, 0); add(0, 1, 3500, M, 1, 0, 1);
    rep(3, 0, 1, M, M, 1, 0, 0); add(0, 1, M, M, 0, 0, 1);
    rep(3, 0, 1, 500, M, 0, 0, 0); add(0, 1, 500, M, 2, 0, 1);
    rep(3, 0, 1, 1100, M, 2, 0, 0);
    rep(3, 0, 1, 1200, M, 2, 0, 0); add(0, 1, 1200, M, 0, 0, 1);
    rep(2, 0, 1, M, 3500, 0, 0, 0); add(0, 1, M, 500, 0, 0, 0);
    rep(3, 0, 1, M, 3500, 0, 0, 0); add(0, 1, M, 3500, 0, 1, 1);
    rep(3, 0, 1, M, M, 0, 1, 0); add(0, 1, M, M, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      add(0, 1, M, 3500, 0, 0, 0);
      add(0, 0, M, 0, 0, 0, 0);
    end
    add(0, 1, M, 3500, 0, 1, 1); add(0, 0, M, M, 0, 1, 0);
    rep(3, 0, 1, M, M, 0, 1, 0); add(0, 1, M, M, 0, 0, 1);
    rep(3, 0, 1, 500, 3800, 0, 0, 0); add(0, 1, 500, 3800, 2, 1, 1); add(0, 0, M, M, 2, 1, 0);
    rep(3, 0, 1, 3500, 3800, 2, 1, 0); add(0, 1, 3500, 3800, 1, 1, 1);
    rep(3, 0, 1, 100, 3800, 1, 1, 0); add(0, 1, 100, 3800, 2, 1, 1);
    rep(2, 0, 1, 3500, 3800, 2, 1, 0); add(1, 1, 500, 3800, 0, 0, 0);
    rep(3, 0, 1, 500, 3800, 0, 0, 0); add(0, 1, 500, 3800, 2, 1, 1);
    foreach (tv[i]) begin
      reset = tv[i].r; j.sample_valid = tv[i].v; j.adc_x = tv[i].x; j.adc_y = tv[i].y;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), j.x_axis, j.y_axis, j.dir_changed, tv[i].ex, tv[i].ey, tv[i].ed);
    end
    reset = 1'b0; j.sample_valid = 1'b0;
    rst1 = 1'b0;
    step1(1, 3500, M, 1, 0, 1, "db1_right");
    step1(1, 3500, M, 1, 0, 0, "db1_hold");
    step1(1, 100, M, 2, 0, 1, "db1_swing");
    step1(0, M, M, 2, 0, 0, "db1_idle");
    step1(1, M, 500, 0, 2, 1, "db1_both");
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule
